instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

- Fetch stage directly upstream of the instruction memory.
- Owns the program counter, drives `PC` into the combinational instruction memory, and captures the returned `Instr` together with its address.
- Captured pairs go into a 2-entry buffer that feeds decode through a valid/ready handshake.
- Handles control-flow redirects from execute by flushing buffered instructions and reloading the PC.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.

Ports:
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RESETn` in 1: asynchronous, active-low reset.
- `PC` out 32: fetch address driven to the instruction memory; the memory indexes words with `PC[31:2]`.
- `Instr` in 32: instruction word returned combinationally for the current `PC`.
- `Redirect` in 1: taken branch or jump from execute.
- `RedirectPC` in 32: target address when `Redirect` = 1.
- `OutValid` out 1: buffer head holds a valid instruction.
- `OutReady` in 1: decode accepts the head this cycle.
- `OutInstr` out 32: head instruction.
- `OutPC` out 32: address of the head instruction.
- `OutPCPlus4` out 32: `OutPC` + 4, modulo 2^32.
- `MisalignErr` out 1: sticky misaligned-redirect flag; see Configuration.

## Operation

- State:
  - `PC` register.
  - 2-entry FIFO of {pc, instr}, with 1-bit read/write pointers and a 2-bit count (0..2).
  - `MisalignErr` flag.
- Pop: `OutValid && OutReady`.
- Push (fetch): `!Redirect && (count < 2 || pop)` and fetch not halted.
  - Writes {`PC`, `Instr`} at the write pointer.
  - Updates `PC <= PC + 4`, wrapping at 2^32.
- Count update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged; allowed when full (count = 2) and when count = 1.
- Redirect has priority over push and pop:
  - count <= 0, pointers <= 0.
  - `PC <= RedirectPC`.
  - The word present on `Instr` that cycle is discarded.
  - A concurrent pop is still a valid handoff to decode. Decode squashes it itself, since the redirect comes from an older instruction.
- `OutValid` = (count != 0). `OutInstr`/`OutPC`/`OutPCPlus4` come from the head entry. When count = 0 they hold the last head contents; they are "don't care" but must not be X after reset.
- No FSM beyond two modes:
  - RUN
  - HALT (only with the macro, on a misaligned redirect; exited only by reset).

## Timing

- Reset values (asynchronous on `RESETn` low):
  - `PC` = `RESET_PC`.
  - count = 0, pointers = 0.
  - `OutValid` = 0; `OutInstr`, `OutPC` = 0; `OutPCPlus4` = 4.
  - `MisalignErr` = 0.
- First edge after reset release: the instruction at `RESET_PC` is pushed. `OutValid` = 1 in the following cycle.
- Fetch-to-output latency: 1 cycle.
- Steady-state throughput: 1 instruction/cycle while `OutReady` = 1.
- With `OutReady` = 0:
  - Two instructions are buffered, then `PC` holds.
  - After `OutReady` returns to 1, the next push occurs in that same cycle (push and pop together), with no bubble.
- Redirect sampled at edge k:
  - `OutValid` = 0 in cycle k+1 and `PC` = target.
  - Target instruction is visible with `OutValid` = 1 in cycle k+2.
- `Redirect` held high for several cycles: each cycle reloads `PC` and keeps the buffer empty.
- `RESETn` asserted mid-transfer: all state returns to reset values immediately; no partial entry survives.

## Configuration

- Macro `FETCH_MISALIGN_CHECK_EN`.
- Defined:
  - A redirect with `RedirectPC[1:0]` != 0 loads `PC` unmasked and sets `MisalignErr` (sticky).
  - The unit enters HALT: no further pushes. Entries already buffered may drain, but the redirect has flushed them.
  - A later `Redirect` still reloads `PC` but does not clear HALT; only reset clears it.
- Undefined:
  - `RedirectPC[1:0]` is forced to 2'b00 when loaded.
  - `MisalignErr` is tied to 0.
  - No HALT mode.

## Test plan

- Reset release, `RESETn` low→high with `OutReady` = 1: `OutPC` sequence 0x0, 0x4, 0x8 on consecutive cycles, each `OutInstr` matching memory word 0, 1, 2, and `OutPCPlus4` = `OutPC` + 4.
- Backpressure: `OutReady` = 0 for 5 cycles from PC 0x0. Count saturates at 2 and `PC` holds at 0x8. On release, outputs 0x0, 0x4, 0x8 follow with no gap and no duplicate.
- Redirect: `RedirectPC` = 0x40 while count = 2. Next cycle `OutValid` = 0 and `PC` = 0x40; the cycle after, `OutPC` = 0x40. The old entries are never presented.
- Simultaneous redirect and pop at count = 1: the popped entry is transferred once, the buffer becomes empty, and fetch resumes at the target.
- Wrap-around: `RedirectPC` = 0xFFFF_FFFC gives `OutPCPlus4` = 0x0; the following fetch has `OutPC` = 0x0.
- Misaligned redirect, `RedirectPC` = 0x42:
  - Macro defined: `MisalignErr` = 1 from the next cycle, `OutValid` stays 0 until reset.
  - Macro undefined: `PC` = 0x40 and `MisalignErr` = 0.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bundle: instruction memory address/data, execute redirect, and the
// decode-facing valid/ready head-of-buffer signals.
interface instr_fetch_unit_if;
  logic [31:0] PC;
  logic [31:0] Instr;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] OutInstr;
  logic [31:0] OutPC;
  logic [31:0] OutPCPlus4;
  logic        MisalignErr;

  // The fetch unit itself drives the memory address and the decode head.
  modport master (
    output PC,
    input  Instr,
    input  Redirect,
    input  RedirectPC,
    output OutValid,
    input  OutReady,
    output OutInstr,
    output OutPC,
    output OutPCPlus4,
    output MisalignErr
  );

  modport slave (
    input  PC,
    output Instr,
    output Redirect,
    output RedirectPC,
    input  OutValid,
    output OutReady,
    input  OutInstr,
    input  OutPC,
    input  OutPCPlus4,
    input  MisalignErr
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, captures {pc, instr} into a 2-entry buffer for decode,
// and flushes/reloads on redirect. Define FETCH_MISALIGN_CHECK_EN for misalign halt.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               CLK,
  input  logic               RESETn,
  instr_fetch_unit_if.master bus
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      fifo_q [2];
  logic [31:0] pc_q,     pc_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q,  count_d;

  logic        pop;
  logic        push;
  logic        halt;
  logic [31:0] redirect_target;
  entry_t      head;

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic {
    MODE_RUN  = 1'b0,
    MODE_HALT = 1'b1
  } mode_e;

  mode_e mode_q,     mode_d;
  logic  misalign_q, misalign_d;
  logic  redirect_misaligned;

  assign redirect_misaligned = bus.Redirect && (bus.RedirectPC[1:0] != 2'b00);
  assign redirect_target     = bus.RedirectPC;
  assign halt                = (mode_q == MODE_HALT);
  assign bus.MisalignErr     = misalign_q;

  // Halt is entered on any misaligned redirect and left only through reset.
  always_comb begin
    mode_d     = mode_q;
    misalign_d = misalign_q;
    if (redirect_misaligned) begin
      mode_d     = MODE_HALT;
      misalign_d = 1'b1;
    end
  end
`else
  logic unused_redirect_low;

  assign unused_redirect_low = ^bus.RedirectPC[1:0];
  assign redirect_target     = {bus.RedirectPC[31:2], 2'b00};
  assign halt                = 1'b0;
  assign bus.MisalignErr     = 1'b0;
`endif

  assign pop  = (count_q != 2'd0) && bus.OutReady;
  // A full buffer may still accept a fetch when the head leaves in the same cycle.
  assign push = !bus.Redirect && ((count_q != 2'd2) || pop) && !halt;

  // NOTE: every variable assigned here gets a default first, so no latch is inferred.
  always_comb begin
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.Redirect) begin
      pc_d     = redirect_target;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      pc_q     <= RESET_PC;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      // NOTE: the buffer storage is reset too, because the head is visible on the
      // outputs while empty and must read as zero rather than X after reset.
      for (int i = 0; i < 2; i++) begin
        fifo_q[i] <= '0;
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      mode_q     <= MODE_RUN;
      misalign_q <= 1'b0;
`endif
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= '{pc: pc_q, instr: bus.Instr};
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      mode_q     <= mode_d;
      misalign_q <= misalign_d;
`endif
    end
  end

  assign head           = fifo_q[rd_ptr_q];
  assign bus.PC         = pc_q;
  assign bus.OutValid   = (count_q != 2'd0);
  assign bus.OutInstr   = head.instr;
  assign bus.OutPC      = head.pc;
  assign bus.OutPCPlus4 = head.pc + 32'd4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic CLK;
  logic RESETn;
  instr_fetch_unit_if bus ();

  instr_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .bus    (bus)
  );

  logic [31:0] mem [0:1023];
  assign bus.Instr = mem[bus.PC[11:2]];

  int errors = 0;
  int checks = 0;

  // Reference model: ordered list of fetched-but-not-consumed words.
  entry_t      m_q[$];
  logic [31:0] m_pc;
  logic        m_err;
  logic        m_halt;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_at(input logic [31:0] addr);
    logic [9:0] idx;
    idx = addr[11:2];
    return mem[idx];
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pc   = RESET_PC;
    m_err  = 1'b0;
    m_halt = 1'b0;
  endtask

  // Drive one cycle's inputs, advance to the next falling edge, update the model.
  task automatic cycle(input logic redir, input logic [31:0] tgt, input logic rdy);
    bus.Redirect   = redir;
    bus.RedirectPC = tgt;
    bus.OutReady   = rdy;
    if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
    if (redir) begin
      m_q.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
      m_pc = tgt;
      if (tgt[1:0] != 2'b00) begin
        m_err  = 1'b1;
        m_halt = 1'b1;
      end
`else
      m_pc = {tgt[31:2], 2'b00};
`endif
    end else if (!m_halt && m_q.size() < 2) begin
      m_q.push_back('{pc: m_pc, instr: mem_at(m_pc)});
      m_pc = m_pc + 32'd4;
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RESETn         = 1'b0;
    bus.Redirect   = 1'b0;
    bus.RedirectPC = 32'h0;
    bus.OutReady   = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    model_reset();
    RESETn = 1'b1;
  endtask

  task automatic test_reset();
    checks++; if (bus.OutValid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus.OutValid); end
    checks++; if (bus.PC !== RESET_PC) begin errors++; $display("FAIL rst_pc: got %h want %h", bus.PC, RESET_PC); end
    checks++; if (bus.OutPC !== 32'h0) begin errors++; $display("FAIL rst_outpc: got %h want 0", bus.OutPC); end
    checks++; if (bus.OutInstr !== 32'h0) begin errors++; $display("FAIL rst_outinstr: got %h want 0", bus.OutInstr); end
    checks++; if (bus.OutPCPlus4 !== 32'h4) begin errors++; $display("FAIL rst_plus4: got %h want 4", bus.OutPCPlus4); end
    checks++; if (bus.MisalignErr !== 1'b0) begin errors++; $display("FAIL rst_misalign: got %b want 0", bus.MisalignErr); end
  endtask

  task automatic test_reset_release();
    logic [31:0] exp_pc;
    do_reset();
    checks++; if (bus.OutValid !== 1'b0) begin errors++; $display("FAIL rel_valid0: got %b want 0", bus.OutValid); end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 32'h0, 1'b1);
      exp_pc = 32'(i * 4);
      checks++; if (bus.OutValid !== 1'b1) begin errors++; $display("FAIL rel_valid[%0d]: got %b want 1", i, bus.OutValid); end
      checks++; if (bus.OutPC !== exp_pc) begin errors++; $display("FAIL rel_pc[%0d]: got %h want %h", i, bus.OutPC, exp_pc); end
      checks++; if (bus.OutInstr !== mem_at(exp_pc)) begin errors++; $display("FAIL rel_instr[%0d]: got %h want %h", i, bus.OutInstr, mem_at(exp_pc)); end
      checks++; if (bus.OutPCPlus4 !== exp_pc + 32'd4) begin errors++; $display("FAIL rel_plus4[%0d]: got %h want %h", i, bus.OutPCPlus4, exp_pc + 32'd4); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc;
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b0);
    checks++; if (bus.PC !== 32'h8) begin errors++; $display("FAIL bp_pc_hold: got %h want 00000008", bus.PC); end
    checks++; if (bus.OutValid !== 1'b1 || bus.OutPC !== 32'h0) begin errors++; $display("FAIL bp_head: got v=%b pc=%h want v=1 pc=0", bus.OutValid, bus.OutPC); end
    for (int i = 0; i < 4; i++) begin
      exp_pc = 32'(i * 4);
      checks++; if (bus.OutValid !== 1'b1 || bus.OutPC !== exp_pc) begin errors++; $display("FAIL bp_drain[%0d]: got v=%b pc=%h want v=1 pc=%h", i, bus.OutValid, bus.OutPC, exp_pc); end
      checks++; if (bus.OutInstr !== mem_at(exp_pc)) begin errors++; $display("FAIL bp_instr[%0d]: got %h want %h", i, bus.OutInstr, mem_at(exp_pc)); end
      cycle(1'b0, 32'h0, 1'b1);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b1, 32'h40, 1'b0);
    checks++; if (bus.OutValid !== 1'b0) begin errors++; $display("FAIL redir_flush: got %b want 0", bus.OutValid); end
    checks++; if (bus.PC !== 32'h40) begin errors++; $display("FAIL redir_pc: got %h want 00000040", bus.PC); end
    cycle(1'b0, 32'h0, 1'b1);
    checks++; if (bus.OutValid !== 1'b1 || bus.OutPC !== 32'h40) begin errors++; $display("FAIL redir_target: got v=%b pc=%h want v=1 pc=00000040", bus.OutValid, bus.OutPC); end
    checks++; if (bus.OutInstr !== mem_at(32'h40)) begin errors++; $display("FAIL redir_instr: got %h want %h", bus.OutInstr, mem_at(32'h40)); end
    cycle(1'b0, 32'h0, 1'b1);
    checks++; if (bus.OutPC !== 32'h44) begin errors++; $display("FAIL redir_next: got %h want 00000044", bus.OutPC); end
  endtask

  task automatic test_redirect_pop();
    do_reset();
    cycle(1'b0, 32'h0, 1'b1);
    checks++; if (bus.OutValid !== 1'b1 || bus.OutPC !== 32'h0) begin errors++; $display("FAIL rp_handoff: got v=%b pc=%h want v=1 pc=0", bus.OutValid, bus.OutPC); end
    cycle(1'b1, 32'h80, 1'b1);
    checks++; if (bus.OutValid !== 1'b0 || bus.PC !== 32'h80) begin errors++; $display("FAIL rp_empty: got v=%b pc=%h want v=0 pc=00000080", bus.OutValid, bus.PC); end
    cycle(1'b0, 32'h0, 1'b1);
    checks++; if (bus.OutValid !== 1'b1 || bus.OutPC !== 32'h80) begin errors++; $display("FAIL rp_resume: got v=%b pc=%h want v=1 pc=00000080", bus.OutValid, bus.OutPC); end
  endtask

  task automatic test_wrap();
    do_reset();
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b1, 32'hFFFF_FFFC, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    checks++; if (bus.OutPC !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc: got %h want fffffffc", bus.OutPC); end
    checks++; if (bus.OutPCPlus4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4: got %h want 00000000", bus.OutPCPlus4); end
    cycle(1'b0, 32'h0, 1'b1);
    checks++; if (bus.OutValid !== 1'b1 || bus.OutPC !== 32'h0) begin errors++; $display("FAIL wrap_next: got v=%b pc=%h want v=1 pc=0", bus.OutValid, bus.OutPC); end
  endtask

  task automatic test_misalign();
    do_reset();
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b1, 32'h42, 1'b1);
`ifdef FETCH_MISALIGN_CHECK_EN
    checks++; if (bus.MisalignErr !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b want 1", bus.MisalignErr); end
    checks++; if (bus.PC !== 32'h42) begin errors++; $display("FAIL mis_pc: got %h want 00000042", bus.PC); end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 32'h0, 1'b1);
      checks++; if (bus.OutValid !== 1'b0) begin errors++; $display("FAIL mis_halt[%0d]: got %b want 0", i, bus.OutValid); end
    end
    cycle(1'b1, 32'h100, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    checks++; if (bus.PC !== 32'h100 || bus.OutValid !== 1'b0 || bus.MisalignErr !== 1'b1) begin errors++; $display("FAIL mis_sticky: got pc=%h v=%b err=%b want pc=00000100 v=0 err=1", bus.PC, bus.OutValid, bus.MisalignErr); end
    do_reset();
    checks++; if (bus.MisalignErr !== 1'b0) begin errors++; $display("FAIL mis_clear: got %b want 0", bus.MisalignErr); end
`else
    checks++; if (bus.PC !== 32'h40) begin errors++; $display("FAIL mis_mask_pc: got %h want 00000040", bus.PC); end
    checks++; if (bus.MisalignErr !== 1'b0) begin errors++; $display("FAIL mis_flag: got %b want 0", bus.MisalignErr); end
    cycle(1'b0, 32'h0, 1'b1);
    checks++; if (bus.OutValid !== 1'b1 || bus.OutPC !== 32'h40) begin errors++; $display("FAIL mis_resume: got v=%b pc=%h want v=1 pc=00000040", bus.OutValid, bus.OutPC); end
`endif
  endtask

  task automatic test_random();
    logic        redir;
    logic        rdy;
    logic [31:0] tgt;
    int          bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      checks++;
      if (bus.OutValid !== (m_q.size() != 0) || bus.PC !== m_pc || bus.MisalignErr !== m_err) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL rnd_state[%0d]: got v=%b pc=%h err=%b want v=%b pc=%h err=%b", i, bus.OutValid, bus.PC, bus.MisalignErr, m_q.size() != 0, m_pc, m_err);
      end
      if (m_q.size() != 0) begin
        checks++;
        if (bus.OutPC !== m_q[0].pc || bus.OutInstr !== m_q[0].instr || bus.OutPCPlus4 !== m_q[0].pc + 32'd4) begin
          errors++; bad++;
          if (bad < 10) $display("FAIL rnd_head[%0d]: got pc=%h instr=%h p4=%h want pc=%h instr=%h", i, bus.OutPC, bus.OutInstr, bus.OutPCPlus4, m_q[0].pc, m_q[0].instr);
        end
      end
      redir = ($urandom_range(7) == 0);
      rdy   = ($urandom_range(3) != 0);
      tgt   = $urandom;
`ifdef FETCH_MISALIGN_CHECK_EN
      tgt[1:0] = 2'b00;
`endif
      cycle(redir, tgt, rdy);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    #2;
    RESETn = 1'b0;
    #1;
    checks++; if (bus.OutValid !== 1'b0 || bus.PC !== RESET_PC) begin errors++; $display("FAIL midrst_state: got v=%b pc=%h want v=0 pc=%h", bus.OutValid, bus.PC, RESET_PC); end
    checks++; if (bus.OutPC !== 32'h0 || bus.OutInstr !== 32'h0 || bus.OutPCPlus4 !== 32'h4) begin errors++; $display("FAIL midrst_head: got pc=%h instr=%h p4=%h want 0 0 4", bus.OutPC, bus.OutInstr, bus.OutPCPlus4); end
    @(negedge CLK);
    model_reset();
    RESETn = 1'b1;
    cycle(1'b0, 32'h0, 1'b1);
    checks++; if (bus.OutValid !== 1'b1 || bus.OutPC !== RESET_PC) begin errors++; $display("FAIL midrst_restart: got v=%b pc=%h want v=1 pc=%h", bus.OutValid, bus.OutPC, RESET_PC); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    RESETn         = 1'b0;
    bus.Redirect   = 1'b0;
    bus.RedirectPC = 32'h0;
    bus.OutReady   = 1'b1;
    model_reset();
    @(negedge CLK);
    test_reset();
    test_reset_release();
    test_backpressure();
    test_redirect();
    test_redirect_pop();
    test_wrap();
    test_misalign();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
